// File: rtl/instr_prefetch_if.sv
// Prefetcher-side bundle: memory read port, redirect, decoder consume and head-window view.
// The master modport is the prefetcher; the slave modport is the memory/decoder environment.
interface instr_prefetch_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8
);
    logic                     mem_req;
    logic [ADDR_WIDTH-1:0]    mem_addr;
    logic [DATA_WIDTH-1:0]    mem_data;
    logic                     jump_valid;
    logic [ADDR_WIDTH-1:0]    jump_pc;
    logic                     consume;
    logic [1:0]               consume_len;
    logic [$clog2(DEPTH):0]   q_count;
    logic [DATA_WIDTH-1:0]    q_byte0;
    logic [DATA_WIDTH-1:0]    q_byte1;
    logic [DATA_WIDTH-1:0]    q_byte2;
    logic [ADDR_WIDTH-1:0]    q_pc;

    modport master (
        output mem_req, mem_addr, q_count, q_byte0, q_byte1, q_byte2, q_pc,
        input  mem_data, jump_valid, jump_pc, consume, consume_len
    );

    modport slave (
        input  mem_req, mem_addr, q_count, q_byte0, q_byte1, q_byte2, q_pc,
        output mem_data, jump_valid, jump_pc, consume, consume_len
    );
endinterface

// File: rtl/instr_prefetch.sv
// Byte prefetch queue fed by a 1-cycle-latency memory; a request's byte lands in the queue 2 cycles after issue.
// Fetch stalls while queue plus in-flight byte would exceed DEPTH; the decoder consumes 1..3 bytes from the head.
module instr_prefetch #(
    parameter int                    ADDR_WIDTH   = 16,
    parameter int                    DATA_WIDTH   = 8,
    parameter int                    DEPTH        = 8,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = 16'h0100
) (
    input  logic           clk,
    input  logic           reset_n,
    instr_prefetch_if.master bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]         head_q, tail_q;
    logic [CW-1:0]         count_q;
    logic [ADDR_WIDTH-1:0] pc_q, fetch_q;
    logic                  inflight_q;

    logic                  issue;
    logic                  cons_ok;
    logic [CW-1:0]         len_ext;

    assign len_ext = CW'(bus.consume_len);
    assign cons_ok = bus.consume && (bus.consume_len != 2'd0) && (len_ext <= count_q);

    // Gated by reset_n so the request port is quiet while reset is held.
    assign issue = reset_n && !bus.jump_valid
                && ((count_q + CW'(inflight_q)) < CW'(DEPTH));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            pc_q       <= RESET_VECTOR;
            fetch_q    <= RESET_VECTOR;
            inflight_q <= 1'b0;
        end else if (bus.jump_valid) begin
            // Redirect flushes the queue and forgets any byte still returning.
            head_q     <= tail_q;
            count_q    <= '0;
            pc_q       <= bus.jump_pc;
            fetch_q    <= bus.jump_pc;
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= issue;
            if (issue) begin
                fetch_q <= fetch_q + ADDR_WIDTH'(1);
            end
            if (inflight_q) begin
                tail_q <= tail_q + PW'(1);
            end
            if (cons_ok) begin
                head_q <= head_q + PW'(bus.consume_len);
                pc_q   <= pc_q + ADDR_WIDTH'(bus.consume_len);
            end
            count_q <= count_q + CW'(inflight_q) - (cons_ok ? len_ext : CW'(0));
        end
    end

    always_ff @(posedge clk) begin
        if (reset_n && !bus.jump_valid && inflight_q) begin
            mem_q[tail_q] <= bus.mem_data;
        end
    end

    assign bus.mem_req  = issue;
    assign bus.mem_addr = fetch_q;
    assign bus.q_count  = count_q;
    assign bus.q_pc     = pc_q;
    assign bus.q_byte0  = (count_q > CW'(0)) ? mem_q[head_q]           : '0;
    assign bus.q_byte1  = (count_q > CW'(1)) ? mem_q[head_q + PW'(1)]  : '0;
    assign bus.q_byte2  = (count_q > CW'(2)) ? mem_q[head_q + PW'(2)]  : '0;
endmodule

// File: tb/tb_instr_prefetch.sv
// Directed vector table for the fetch/consume/jump/reset corners, then randomized traffic
// checked every cycle against a queue-based reference model.
module tb_instr_prefetch;
    localparam int AW    = 16;
    localparam int DW    = 8;
    localparam int DEPTH = 8;

    logic clk;
    logic reset_n;

    instr_prefetch_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

    instr_prefetch #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .RESET_VECTOR(16'h0100)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        jv;
        logic [15:0] jpc;
        logic        cons;
        logic [1:0]  len;
        logic        e_req;
        logic [15:0] e_addr;
        logic [3:0]  e_cnt;
        logic [15:0] e_pc;
        logic [7:0]  e_b0;
        logic [7:0]  e_b1;
        logic [7:0]  e_b2;
    } vec_t;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: the queue contents as a plain byte queue.
    logic [7:0]  mq[$];
    logic [15:0] m_pc, m_fa;
    logic        m_pend;
    logic [7:0]  m_pend_byte;
    logic        m_req_now;

    // Memory responder: answers whatever the DUT actually requested, one cycle later.
    logic        mem_pend, nxt_pend;
    logic [7:0]  mem_byte, nxt_byte;

    function automatic logic [60:0] pack(input logic req, input logic [15:0] addr, input logic [3:0] cnt,
                                         input logic [15:0] pc, input logic [7:0] b0, input logic [7:0] b1,
                                         input logic [7:0] b2);
        return {req, (req ? addr : 16'h0), cnt, pc, b0, b1, b2};
    endfunction

    function automatic logic [60:0] dut_state();
        return pack(bus.mem_req, bus.mem_addr, bus.q_count, bus.q_pc, bus.q_byte0, bus.q_byte1, bus.q_byte2);
    endfunction

    task automatic compare(input string name, input logic [60:0] act, input logic [60:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got req=%b addr=%h cnt=%0d pc=%h bytes=%h, want req=%b addr=%h cnt=%0d pc=%h bytes=%h",
                     name, $time, act[60], act[59:44], act[43:40], act[39:24], act[23:0],
                     exp[60], exp[59:44], exp[43:40], exp[39:24], exp[23:0]);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_pc     = 16'h0100;
        m_fa     = 16'h0100;
        m_pend   = 1'b0;
        mem_pend = 1'b0;
    endtask

    function automatic logic [7:0] mbyte(input int i);
        return (i < mq.size()) ? mq[i] : 8'h00;
    endfunction

    task automatic check_model(input string name);
        compare(name, dut_state(),
                pack(m_req_now, m_fa, 4'(mq.size()), m_pc, mbyte(0), mbyte(1), mbyte(2)));
    endtask

    task automatic apply(input logic jv, input logic [15:0] jpc, input logic cons, input logic [1:0] len);
        bus.jump_valid  = jv;
        bus.jump_pc     = jpc;
        bus.consume     = cons;
        bus.consume_len = len;
        bus.mem_data    = mem_pend ? mem_byte : 8'($urandom);
        m_req_now       = reset_n && !jv && ((mq.size() + int'(m_pend)) < DEPTH);
        #1;
    endtask

    task automatic advance(input logic jv, input logic [15:0] jpc, input logic cons, input logic [1:0] len);
        nxt_pend = bus.mem_req;
        nxt_byte = bus.mem_addr[7:0];
        @(posedge clk);
        if (jv) begin
            mq.delete();
            m_pc   = jpc;
            m_fa   = jpc;
            m_pend = 1'b0;
        end else begin
            if (cons && len != 2'd0 && int'(len) <= mq.size()) begin
                repeat (int'(len)) void'(mq.pop_front());
                m_pc = m_pc + 16'(len);
            end
            if (m_pend) mq.push_back(m_pend_byte);
            m_pend = m_req_now;
            if (m_req_now) begin
                m_pend_byte = m_fa[7:0];
                m_fa        = m_fa + 16'd1;
            end
        end
        mem_pend = nxt_pend;
        mem_byte = nxt_byte;
        @(negedge clk);
    endtask

    function automatic vec_t mk(input logic jv, input logic [15:0] jpc, input logic cons, input logic [1:0] len,
                                input logic req, input logic [15:0] addr, input logic [3:0] cnt,
                                input logic [15:0] pc, input logic [7:0] b0, input logic [7:0] b1,
                                input logic [7:0] b2);
        vec_t v;
        v.jv = jv; v.jpc = jpc; v.cons = cons; v.len = len;
        v.e_req = req; v.e_addr = addr; v.e_cnt = cnt; v.e_pc = pc;
        v.e_b0 = b0; v.e_b1 = b1; v.e_b2 = b2;
        return v;
    endfunction

    vec_t tv[26];

    initial begin
        logic        jv, cons;
        logic [15:0] jpc;
        logic [1:0]  len;

        // Cycle 1 is the first cycle after reset_n rises; memory returns addr[7:0].
        tv[0]  = mk(0, 16'h0000, 0, 0, 1, 16'h0100, 0, 16'h0100, 8'h00, 8'h00, 8'h00);
        tv[1]  = mk(0, 16'h0000, 0, 0, 1, 16'h0101, 0, 16'h0100, 8'h00, 8'h00, 8'h00);
        tv[2]  = mk(0, 16'h0000, 0, 0, 1, 16'h0102, 1, 16'h0100, 8'h00, 8'h00, 8'h00);
        tv[3]  = mk(0, 16'h0000, 0, 0, 1, 16'h0103, 2, 16'h0100, 8'h00, 8'h01, 8'h00);
        tv[4]  = mk(0, 16'h0000, 0, 0, 1, 16'h0104, 3, 16'h0100, 8'h00, 8'h01, 8'h02);
        tv[5]  = mk(0, 16'h0000, 0, 0, 1, 16'h0105, 4, 16'h0100, 8'h00, 8'h01, 8'h02);
        tv[6]  = mk(0, 16'h0000, 0, 0, 1, 16'h0106, 5, 16'h0100, 8'h00, 8'h01, 8'h02);
        tv[7]  = mk(0, 16'h0000, 0, 0, 1, 16'h0107, 6, 16'h0100, 8'h00, 8'h01, 8'h02);
        tv[8]  = mk(0, 16'h0000, 0, 0, 0, 16'h0000, 7, 16'h0100, 8'h00, 8'h01, 8'h02);
        tv[9]  = mk(0, 16'h0000, 1, 3, 0, 16'h0000, 8, 16'h0100, 8'h00, 8'h01, 8'h02);
        tv[10] = mk(0, 16'h0000, 0, 0, 1, 16'h0108, 5, 16'h0103, 8'h03, 8'h04, 8'h05);
        tv[11] = mk(0, 16'h0000, 0, 0, 1, 16'h0109, 5, 16'h0103, 8'h03, 8'h04, 8'h05);
        tv[12] = mk(0, 16'h0000, 0, 0, 1, 16'h010A, 6, 16'h0103, 8'h03, 8'h04, 8'h05);
        tv[13] = mk(0, 16'h0000, 0, 0, 0, 16'h0000, 7, 16'h0103, 8'h03, 8'h04, 8'h05);
        tv[14] = mk(1, 16'h2000, 1, 3, 0, 16'h0000, 8, 16'h0103, 8'h03, 8'h04, 8'h05);
        tv[15] = mk(0, 16'h0000, 0, 0, 1, 16'h2000, 0, 16'h2000, 8'h00, 8'h00, 8'h00);
        tv[16] = mk(0, 16'h0000, 0, 0, 1, 16'h2001, 0, 16'h2000, 8'h00, 8'h00, 8'h00);
        tv[17] = mk(0, 16'h0000, 0, 0, 1, 16'h2002, 1, 16'h2000, 8'h00, 8'h00, 8'h00);
        tv[18] = mk(0, 16'h0000, 1, 3, 1, 16'h2003, 2, 16'h2000, 8'h00, 8'h01, 8'h00);
        tv[19] = mk(1, 16'hFFFE, 0, 0, 0, 16'h0000, 3, 16'h2000, 8'h00, 8'h01, 8'h02);
        tv[20] = mk(0, 16'h0000, 0, 0, 1, 16'hFFFE, 0, 16'hFFFE, 8'h00, 8'h00, 8'h00);
        tv[21] = mk(0, 16'h0000, 0, 0, 1, 16'hFFFF, 0, 16'hFFFE, 8'h00, 8'h00, 8'h00);
        tv[22] = mk(0, 16'h0000, 0, 0, 1, 16'h0000, 1, 16'hFFFE, 8'hFE, 8'h00, 8'h00);
        tv[23] = mk(0, 16'h0000, 0, 0, 1, 16'h0001, 2, 16'hFFFE, 8'hFE, 8'hFF, 8'h00);
        tv[24] = mk(0, 16'h0000, 0, 0, 1, 16'h0002, 3, 16'hFFFE, 8'hFE, 8'hFF, 8'h00);
        tv[25] = mk(0, 16'h0000, 0, 0, 1, 16'h0003, 4, 16'hFFFE, 8'hFE, 8'hFF, 8'h00);

        reset_n         = 1'b0;
        bus.jump_valid  = 1'b0;
        bus.jump_pc     = '0;
        bus.consume     = 1'b0;
        bus.consume_len = '0;
        bus.mem_data    = '0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        #1;
        compare("reset_state", dut_state(), pack(0, 16'h0, 4'd0, 16'h0100, 8'h00, 8'h00, 8'h00));
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 26; i++) begin
            apply(tv[i].jv, tv[i].jpc, tv[i].cons, tv[i].len);
            compare($sformatf("table_%0d", i + 1), dut_state(),
                    pack(tv[i].e_req, tv[i].e_addr, tv[i].e_cnt, tv[i].e_pc, tv[i].e_b0, tv[i].e_b1, tv[i].e_b2));
            check_model($sformatf("model_tab_%0d", i + 1));
            advance(tv[i].jv, tv[i].jpc, tv[i].cons, tv[i].len);
        end

        // Reset pulsed mid-cycle with five bytes queued and a byte in flight.
        apply(0, 16'h0, 0, 0);
        compare("pre_reset", dut_state(), pack(1, 16'h0004, 4'd5, 16'hFFFE, 8'hFE, 8'hFF, 8'h00));
        #1 reset_n = 1'b0;
        #1;
        compare("reset_async", dut_state(), pack(0, 16'h0, 4'd0, 16'h0100, 8'h00, 8'h00, 8'h00));
        @(negedge clk);
        #1;
        compare("reset_hold", dut_state(), pack(0, 16'h0, 4'd0, 16'h0100, 8'h00, 8'h00, 8'h00));
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        apply(0, 16'h0, 0, 0);
        compare("post_reset_req", dut_state(), pack(1, 16'h0100, 4'd0, 16'h0100, 8'h00, 8'h00, 8'h00));
        advance(0, 16'h0, 0, 0);
        for (int c = 2; c <= 10; c++) begin
            apply(0, 16'h0, 0, 0);
            check_model($sformatf("refill_%0d", c));
            if (c == 10) begin
                compare("refill_full", dut_state(), pack(0, 16'h0, 4'd8, 16'h0100, 8'h00, 8'h01, 8'h02));
            end
            advance(0, 16'h0, 0, 0);
        end

        for (int c = 0; c < 600; c++) begin
            jv   = ($urandom_range(0, 19) == 0);
            jpc  = 16'($urandom);
            cons = ($urandom_range(0, 2) != 0);
            len  = 2'($urandom_range(0, 3));
            apply(jv, jpc, cons, len);
            check_model("random");
            advance(jv, jpc, cons, len);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
